// File: rtl/sfx_sequencer.sv
// Sound-effect voice: plays a 4-note square-wave jingle for eat/hit/die triggers.
// Optional SFX_ENVELOPE_EN adds a decaying volume envelope applied via a 4-bit PWM gate.
module sfx_sequencer #(
  parameter int FRAMES_PER_NOTE = 4,
  parameter int DIV_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       eat_sound,
  input  logic       hit_sound,
  input  logic       die_sound,
  input  logic       mute,
  output logic       sound_out,
  output logic       busy,
  output logic [1:0] sfx_id,
  output logic [3:0] volume
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state, state_n;
  logic [1:0]         sfx_id_n;
  logic [1:0]         note_idx, note_idx_n;
  logic [3:0]         frame_cnt, frame_cnt_n;
  logic [DIV_W-1:0]   div_cnt, div_cnt_n;
  logic               sq, sq_n;
  logic [3:0]         volume_n;
  logic               sound_n;
  logic [1:0]         req_id;
  logic               accept;
  logic [DIV_W-1:0]   half;
  logic               env_gate;

  // Half-period in clk cycles; zero marks a rest note.
  function automatic logic [DIV_W-1:0] half_lookup(input logic [1:0] id, input logic [1:0] note);
    logic [DIV_W-1:0] h;
    h = '0;
    case (id)
      2'd1: case (note)
        2'd0: h = DIV_W'(9000);
        2'd1: h = DIV_W'(7500);
        2'd2: h = DIV_W'(6000);
        default: h = DIV_W'(4500);
      endcase
      2'd2: case (note)
        2'd0: h = DIV_W'(15000);
        2'd2: h = DIV_W'(15000);
        default: h = '0;
      endcase
      2'd3: case (note)
        2'd0: h = DIV_W'(8000);
        2'd1: h = DIV_W'(11000);
        2'd2: h = DIV_W'(16000);
        default: h = DIV_W'(24000);
      endcase
      default: h = '0;
    endcase
    return h;
  endfunction

`ifdef SFX_ENVELOPE_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign env_gate = (pwm_cnt < volume);
`else
  assign env_gate = 1'b1;
`endif

  assign busy = (state == PLAY);

  always_comb begin
    req_id = die_sound ? 2'd3 : hit_sound ? 2'd2 : eat_sound ? 2'd1 : 2'd0;
    accept = (req_id != 2'd0) && ((state == IDLE) || (req_id >= sfx_id));
    half   = half_lookup(sfx_id, note_idx);
  end

  always_comb begin
    state_n     = state;
    sfx_id_n    = sfx_id;
    note_idx_n  = note_idx;
    frame_cnt_n = frame_cnt;
    div_cnt_n   = div_cnt;
    sq_n        = sq;
    volume_n    = volume;
    if (accept) begin
      state_n     = PLAY;
      sfx_id_n    = req_id;
      note_idx_n  = 2'd0;
      frame_cnt_n = 4'd0;
      div_cnt_n   = '0;
      sq_n        = 1'b0;
      volume_n    = 4'd15;
    end else if (state == PLAY) begin
      if (half == '0) begin
        div_cnt_n = '0;
        sq_n      = 1'b0;
      end else if (div_cnt == half - DIV_W'(1)) begin
        div_cnt_n = '0;
        sq_n      = ~sq;
      end else begin
        div_cnt_n = div_cnt + DIV_W'(1);
      end
      if (frame_end) begin
`ifdef SFX_ENVELOPE_EN
        volume_n = (volume == 4'd0) ? 4'd0 : volume - 4'd1;
`endif
        if (frame_cnt == 4'(FRAMES_PER_NOTE - 1)) begin
          frame_cnt_n = 4'd0;
          div_cnt_n   = '0;
          sq_n        = 1'b0;
          note_idx_n  = note_idx + 2'd1;
          if (note_idx == 2'd3) begin
            state_n  = IDLE;
            sfx_id_n = 2'd0;
            volume_n = 4'd0;
          end
        end else begin
          frame_cnt_n = frame_cnt + 4'd1;
        end
      end
    end
    // Gating with the next state keeps the pin low from the first IDLE cycle.
    sound_n = sq & ~mute & env_gate & (state_n == PLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sfx_id    <= 2'd0;
      note_idx  <= 2'd0;
      frame_cnt <= 4'd0;
      div_cnt   <= '0;
      sq        <= 1'b0;
      volume    <= 4'd0;
      sound_out <= 1'b0;
    end else begin
      state     <= state_n;
      sfx_id    <= sfx_id_n;
      note_idx  <= note_idx_n;
      frame_cnt <= frame_cnt_n;
      div_cnt   <= div_cnt_n;
      sq        <= sq_n;
      volume    <= volume_n;
      sound_out <= sound_n;
    end
  end

endmodule
